cam_capture: RTL and testbench

Camera capture front end that sits directly upstream of the pixel FIFO. It samples the sensor's 8-bit parallel bus (VSYNC/HREF/D[7:0], RGB565, two bytes per pixel) on `pclk`. It packs each pixel into RGB332 and issues one-cycle write strobes (`datasave`, `wr`) into the FIFO. It also handles frame gating and line/frame length checking, and drops pixels rather than writing while the FIFO reports full.

---
 rtl/cam_capture_if.sv | 16 +
 rtl/cam_capture.sv | 105 ++++++++++
 tb/tb_cam_capture.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// cam_capture_if: sensor byte bus plus pixel FIFO write port
// Ports (signals):
//   vsync, href, d[7:0] : sensor VSYNC, HREF and data byte
//   full                : FIFO full flag
//   datasave[7:0], wr   : RGB332 pixel and one-cycle write strobe to FIFO
// Modports: master = sensor/FIFO side, slave = capture block
interface cam_capture_if;
   logic       vsync;
   logic       href;
   logic [7:0] d;
   logic       full;
   logic [7:0] datasave;
   logic       wr;
   modport master(output vsync, href, d, full, input datasave, wr);
   modport slave(input vsync, href, d, full, output datasave, wr);
endinterface

// File: rtl/cam_capture.sv
// cam_capture: RGB565 byte-stream capture, RGB332 packing and FIFO write with frame gating and length checks
// Ports:
//   pclk       : sensor pixel clock, all logic on the rising edge
//   reset      : synchronous active-low reset
//   enable     : level, capture frames while high
//   single     : sampled at frame start, capture one frame then go idle
//   bus        : sensor bus (vsync, href, d) and FIFO port (full, datasave, wr)
//   busy       : waiting for a frame or capturing
//   frame_done : one-cycle pulse at end of each captured frame
//   overflow   : sticky, a pixel was dropped on FIFO full
//   err        : sticky, bad line length, odd byte count or bad line count
//   frame_cnt  : captured frames, wraps
module cam_capture #(
   parameter int H_PIX   = 160,
   parameter int V_LINES = 120,
   parameter int CNT_W   = 9
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              enable,
   input  logic              single,
   cam_capture_if.slave      bus,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   output logic              err,
   output logic [7:0]        frame_cnt
);
   typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;
   state_t state, state_nx;
   logic vsync_q, href_q, phase, single_q;
   logic [7:0] hi;
   logic [CNT_W-1:0] col, line, line_nx;
   logic vs_fall, vs_rise, h_fall, cap, start;
   assign vs_fall = vsync_q & ~bus.vsync;
   assign vs_rise = ~vsync_q & bus.vsync;
   assign h_fall  = href_q & ~bus.href;
   assign cap     = state == CAPTURE;
   assign busy    = state != IDLE;
   assign start   = state == WAIT_FRAME && state_nx == CAPTURE;
   // line count including a line ending on this same edge, so a coincident
   // HREF fall is counted before the end-of-frame check
   assign line_nx = (h_fall && !(&line)) ? line + 1'b1 : line;
   always_ff @(posedge pclk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (state == IDLE)            state_nx = enable ? WAIT_FRAME : IDLE;
      else if (state == WAIT_FRAME) state_nx = !enable ? IDLE : vs_fall ? CAPTURE : WAIT_FRAME;
      else if (vs_rise)             state_nx = (single_q || !enable) ? IDLE : WAIT_FRAME;
   end
   always_ff @(posedge pclk) begin
      if (!reset) begin
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         phase        <= 1'b0;
         single_q     <= 1'b0;
         hi           <= '0;
         col          <= '0;
         line         <= '0;
         bus.wr       <= 1'b0;
         bus.datasave <= '0;
         frame_done   <= 1'b0;
         overflow     <= 1'b0;
         err          <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         vsync_q    <= bus.vsync;
         href_q     <= bus.href;
         bus.wr     <= 1'b0;
         frame_done <= 1'b0;
         if (start) begin
            col      <= '0;
            line     <= '0;
            phase    <= 1'b0;
            single_q <= single;
         end
         if (cap) begin
            phase <= bus.href & ~phase;
            if (bus.href && !phase) hi <= bus.d;
            if (bus.href && phase) begin
               col <= (&col) ? col : col + 1'b1;
               if (bus.full) overflow <= 1'b1;
               else begin
                  bus.wr       <= 1'b1;
                  bus.datasave <= {hi[7:5], hi[2:0], bus.d[4:3]};
               end
            end
            // phase still 1 here means the line ended on an unpaired byte
            if (h_fall) begin
               if (col != CNT_W'(H_PIX) || phase) err <= 1'b1;
               col <= '0;
            end
            line <= line_nx;
            if (vs_rise) begin
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + 1'b1;
               if (line_nx != CNT_W'(V_LINES)) err <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: scoreboard bench for cam_capture with H_PIX=4, V_LINES=2
module tb_cam_capture;
   logic pclk = 1'b0, reset = 1'b0, enable = 1'b0, single = 1'b0;
   logic busy, frame_done, overflow, err;
   logic [7:0] frame_cnt;
   int vectors = 0, misses = 0, fd_cnt = 0, wr_dbl = 0;
   bit wr_prev = 1'b0;
   logic [7:0] exp_q[$], got_q[$];
   logic [7:0] g, e;
   cam_capture_if bus();
   cam_capture #(.H_PIX(4), .V_LINES(2), .CNT_W(9)) dut (
      .pclk(pclk), .reset(reset), .enable(enable), .single(single), .bus(bus),
      .busy(busy), .frame_done(frame_done), .overflow(overflow), .err(err), .frame_cnt(frame_cnt)
   );
   always #5 pclk = ~pclk;
   always @(negedge pclk) begin
      if (bus.wr === 1'b1) got_q.push_back(bus.datasave);
      if (bus.wr === 1'b1 && wr_prev) wr_dbl++;
      if (frame_done === 1'b1) fd_cnt++;
      wr_prev = (bus.wr === 1'b1);
   end
   task automatic tick;
      @(posedge pclk);
      #1;
   endtask
   task automatic do_reset;
      reset = 1'b0; enable = 1'b0; single = 1'b0;
      bus.vsync = 1'b0; bus.href = 1'b0; bus.full = 1'b0; bus.d = 8'h00;
      tick; tick;
      reset = 1'b1;
      exp_q.delete(); got_q.delete(); fd_cnt = 0; wr_dbl = 0;
   endtask
   task automatic frame_start;
      bus.vsync = 1'b1;
      repeat (3) tick;
      bus.vsync = 1'b0;
      repeat (2) tick;
   endtask
   task automatic frame_end;
      bus.href = 1'b0; bus.vsync = 1'b1;
      repeat (2) tick;
   endtask
   task automatic drive_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] ex, input int full_pix, input bit cap, input bit last);
      for (int b = 0; b < nbytes; b++) begin
         bus.href = 1'b1;
         bus.d = b[0] ? lo : hi;
         bus.full = (b / 2 == full_pix);
         if (b[0] && cap && !bus.full) exp_q.push_back(ex);
         tick;
      end
      bus.href = 1'b0; bus.full = 1'b0;
      if (last) bus.vsync = 1'b1;
      repeat (2) tick;
   endtask
   task automatic test_reset;
      bus.vsync = 1'b0; bus.href = 1'b0; bus.full = 1'b0; bus.d = 8'h00;
      reset = 1'b0;
      tick;
      vectors++; if (bus.datasave !== 8'h00) begin misses++; $display("FAIL reset_datasave got %h want 00", bus.datasave); end
      vectors++; if (bus.wr !== 1'b0) begin misses++; $display("FAIL reset_wr got %b want 0", bus.wr); end
      vectors++; if (busy !== 1'b0) begin misses++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (frame_done !== 1'b0) begin misses++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      vectors++; if (overflow !== 1'b0) begin misses++; $display("FAIL reset_overflow got %b want 0", overflow); end
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL reset_err got %b want 0", err); end
      vectors++; if (frame_cnt !== 8'h00) begin misses++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
      reset = 1'b1;
      tick;
      vectors++; if (busy !== 1'b0) begin misses++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask
   task automatic test_nominal;
      do_reset;
      enable = 1'b1;
      tick;
      vectors++; if (busy !== 1'b1) begin misses++; $display("FAIL nominal_busy got %b want 1", busy); end
      frame_start;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != 8) begin misses++; $display("FAIL nominal_wr_count got %0d want 8", got_q.size()); end
      vectors++; if (got_q.size() != exp_q.size()) begin misses++; $display("FAIL nominal_sb_size got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++; if (g !== e) begin misses++; $display("FAIL nominal_pixel got %h want %h", g, e); end
      end
      vectors++; if (fd_cnt != 1) begin misses++; $display("FAIL nominal_frame_done got %0d want 1", fd_cnt); end
      vectors++; if (frame_cnt !== 8'd1) begin misses++; $display("FAIL nominal_frame_cnt got %0d want 1", frame_cnt); end
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL nominal_err got %b want 0", err); end
      vectors++; if (overflow !== 1'b0) begin misses++; $display("FAIL nominal_overflow got %b want 0", overflow); end
      vectors++; if (wr_dbl != 0) begin misses++; $display("FAIL nominal_wr_back_to_back got %0d want 0", wr_dbl); end
      vectors++; if (busy !== 1'b1) begin misses++; $display("FAIL nominal_rearm_busy got %b want 1", busy); end
   endtask
   task automatic test_packing;
      do_reset;
      enable = 1'b1;
      frame_start;
      bus.href = 1'b1; bus.d = 8'h07;
      tick;
      bus.d = 8'hE0;
      tick;
      exp_q.push_back(8'h1C);
      vectors++; if (bus.wr !== 1'b1) begin misses++; $display("FAIL packing_latency_wr got %b want 1", bus.wr); end
      vectors++; if (bus.datasave !== 8'h1C) begin misses++; $display("FAIL packing_latency_data got %h want 1c", bus.datasave); end
      bus.d = 8'h07;
      tick;
      vectors++; if (bus.wr !== 1'b0) begin misses++; $display("FAIL packing_wr_width got %b want 0", bus.wr); end
      bus.d = 8'hE0;
      tick;
      exp_q.push_back(8'h1C);
      drive_line(4, 8'h07, 8'hE0, 8'h1C, -1, 1'b1, 1'b0);
      drive_line(8, 8'h07, 8'hE0, 8'h1C, -1, 1'b1, 1'b0);
      frame_end;
      frame_start;
      drive_line(8, 8'h00, 8'h18, 8'h03, -1, 1'b1, 1'b0);
      drive_line(8, 8'h00, 8'h18, 8'h03, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != exp_q.size()) begin misses++; $display("FAIL packing_sb_size got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++; if (g !== e) begin misses++; $display("FAIL packing_pixel got %h want %h", g, e); end
      end
      vectors++; if (frame_cnt !== 8'd2) begin misses++; $display("FAIL packing_frame_cnt got %0d want 2", frame_cnt); end
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL packing_err got %b want 0", err); end
   endtask
   task automatic test_backpressure;
      do_reset;
      enable = 1'b1;
      frame_start;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, 1, 1'b1, 1'b0);
      vectors++; if (overflow !== 1'b1) begin misses++; $display("FAIL bp_overflow got %b want 1", overflow); end
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != 7) begin misses++; $display("FAIL bp_wr_count got %0d want 7", got_q.size()); end
      frame_start;
      drive_line(8, 8'h07, 8'hE0, 8'h1C, -1, 1'b1, 1'b0);
      drive_line(8, 8'h07, 8'hE0, 8'h1C, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != exp_q.size()) begin misses++; $display("FAIL bp_sb_size got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++; if (g !== e) begin misses++; $display("FAIL bp_pixel got %h want %h", g, e); end
      end
      vectors++; if (overflow !== 1'b1) begin misses++; $display("FAIL bp_overflow_sticky got %b want 1", overflow); end
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL bp_err got %b want 0", err); end
   endtask
   task automatic test_length;
      do_reset;
      enable = 1'b1;
      frame_start;
      drive_line(6, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      vectors++; if (err !== 1'b1) begin misses++; $display("FAIL short_line_err got %b want 1", err); end
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != 7) begin misses++; $display("FAIL short_line_wr_count got %0d want 7", got_q.size()); end
      // nine bytes: four whole pixels so the column count is right and only the odd byte is at fault
      do_reset;
      enable = 1'b1;
      frame_start;
      drive_line(9, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      vectors++; if (err !== 1'b1) begin misses++; $display("FAIL odd_byte_err got %b want 1", err); end
      drive_line(9, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != 8) begin misses++; $display("FAIL odd_byte_wr_count got %0d want 8", got_q.size()); end
      do_reset;
      enable = 1'b1;
      frame_start;
      repeat (3) drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL extra_line_pre_err got %b want 0", err); end
      frame_end;
      vectors++; if (err !== 1'b1) begin misses++; $display("FAIL extra_line_err got %b want 1", err); end
      do_reset;
      enable = 1'b1;
      frame_start;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b1);
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL coincident_edges_err got %b want 0", err); end
      vectors++; if (fd_cnt != 1) begin misses++; $display("FAIL coincident_edges_frame_done got %0d want 1", fd_cnt); end
      vectors++; if (frame_cnt !== 8'd1) begin misses++; $display("FAIL coincident_edges_frame_cnt got %0d want 1", frame_cnt); end
   endtask
   task automatic test_single_gating;
      do_reset;
      enable = 1'b1; single = 1'b1;
      frame_start;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b1, 1'b0);
      bus.vsync = 1'b1;
      tick;
      vectors++; if (busy !== 1'b0) begin misses++; $display("FAIL single_busy got %b want 0", busy); end
      enable = 1'b0; single = 1'b0;
      tick;
      frame_start;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b0, 1'b0);
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b0, 1'b0);
      frame_end;
      vectors++; if (frame_cnt !== 8'd1) begin misses++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
      frame_start;
      enable = 1'b1;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b0, 1'b0);
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b0, 1'b0);
      frame_end;
      vectors++; if (fd_cnt != 1) begin misses++; $display("FAIL gating_frame_done got %0d want 1", fd_cnt); end
      frame_start;
      drive_line(8, 8'h00, 8'h18, 8'h03, -1, 1'b1, 1'b0);
      drive_line(8, 8'h00, 8'h18, 8'h03, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != exp_q.size()) begin misses++; $display("FAIL gating_sb_size got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++; if (g !== e) begin misses++; $display("FAIL gating_pixel got %h want %h", g, e); end
      end
      vectors++; if (frame_cnt !== 8'd2) begin misses++; $display("FAIL gating_frame_cnt got %0d want 2", frame_cnt); end
   endtask
   task automatic test_reset_mid;
      do_reset;
      enable = 1'b1;
      frame_start;
      for (int b = 0; b < 4; b++) begin
         bus.href = 1'b1; bus.d = b[0] ? 8'h1F : 8'hF8;
         if (b[0]) exp_q.push_back(8'hE3);
         tick;
      end
      bus.d = 8'hF8; reset = 1'b0;
      tick;
      vectors++; if (bus.wr !== 1'b0) begin misses++; $display("FAIL midreset_wr got %b want 0", bus.wr); end
      vectors++; if (bus.datasave !== 8'h00) begin misses++; $display("FAIL midreset_datasave got %h want 00", bus.datasave); end
      vectors++; if (busy !== 1'b0) begin misses++; $display("FAIL midreset_busy got %b want 0", busy); end
      reset = 1'b1;
      for (int b = 1; b < 4; b++) begin
         bus.d = b[0] ? 8'h1F : 8'hF8;
         tick;
      end
      bus.href = 1'b0;
      repeat (2) tick;
      drive_line(8, 8'hF8, 8'h1F, 8'hE3, -1, 1'b0, 1'b0);
      frame_end;
      vectors++; if (fd_cnt != 0) begin misses++; $display("FAIL midreset_partial_frame_done got %0d want 0", fd_cnt); end
      frame_start;
      drive_line(8, 8'h07, 8'hE0, 8'h1C, -1, 1'b1, 1'b0);
      drive_line(8, 8'h07, 8'hE0, 8'h1C, -1, 1'b1, 1'b0);
      frame_end;
      vectors++; if (got_q.size() != exp_q.size()) begin misses++; $display("FAIL midreset_sb_size got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         vectors++; if (g !== e) begin misses++; $display("FAIL midreset_pixel got %h want %h", g, e); end
      end
      vectors++; if (frame_cnt !== 8'd1) begin misses++; $display("FAIL midreset_frame_cnt got %0d want 1", frame_cnt); end
      vectors++; if (err !== 1'b0) begin misses++; $display("FAIL midreset_err got %b want 0", err); end
   endtask
   initial begin
      test_reset;
      test_nominal;
      test_packing;
      test_backpressure;
      test_length;
      test_single_gating;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule
